// File: rtl/apb_ram_arbiter.sv
// Round-robin APB master that shares one APB slave between NREQ req/done requesters.
// Latency: with a zero-wait slave, done follows 3 cycles after grant; each pready=0 cycle adds 1, abort after TIMEOUT.
// Backpressure: requesters hold req until their one-cycle done pulse; the slave stalls via pready.
module apb_ram_arbiter #(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 16
) (
   input  logic                 pclk,
   input  logic                 presetn,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      req_write,
   input  logic [32*NREQ-1:0]   req_addr,
   input  logic [32*NREQ-1:0]   req_wdata,
   output logic [NREQ-1:0]      done,
   output logic [31:0]          rsp_rdata,
   output logic                 rsp_err,
   output logic                 rsp_timeout,
   output logic                 psel,
   output logic                 penable,
   output logic                 pwrite,
   output logic [31:0]          paddr,
   output logic [31:0]          pwdata,
   input  logic [31:0]          prdata,
   input  logic                 pready,
   input  logic                 pslverr
);

   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

   state_t          state, nxt_state;
   logic [GW-1:0]   last_grant;
   logic [GW-1:0]   grant;
   logic [CW-1:0]   wait_cnt;

   logic            found;
   logic [GW-1:0]   winner;
   logic            win_write;
   logic [31:0]     win_addr;
   logic [31:0]     win_wdata;
   logic            timeout_hit;
   int              idx;

   // Round-robin pick starting after last_grant, plus next-state decode
   always_comb begin
      nxt_state   = state;
      found       = 1'b0;
      winner      = '0;
      win_write   = 1'b0;
      win_addr    = '0;
      win_wdata   = '0;
      idx         = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last_grant) + k) % NREQ;
         if (!found && req[idx]) begin
            found     = 1'b1;
            winner    = GW'(idx);
            win_write = req_write[idx];
            win_addr  = req_addr[32*idx +: 32];
            win_wdata = req_wdata[32*idx +: 32];
         end
      end
      // The counter holds the number of pready=0 samples already taken,
      // so this is the TIMEOUT-th consecutive stall.
      timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));
      case (state)
         IDLE:    if (found) nxt_state = SETUP;
         SETUP:   nxt_state = ACCESS;
         ACCESS:  if (pready || timeout_hit) nxt_state = DONE;
         DONE:    nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge pclk) begin
      if (!presetn) state <= IDLE;
      else          state <= nxt_state;
   end

   // APB controls, latched request and response registers
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         last_grant  <= GW'(NREQ - 1);
         grant       <= '0;
         wait_cnt    <= '0;
         psel        <= 1'b0;
         penable     <= 1'b0;
         pwrite      <= 1'b0;
         paddr       <= '0;
         pwdata      <= '0;
         done        <= '0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  pwrite     <= win_write;
                  paddr      <= win_addr;
                  pwdata     <= win_wdata;
                  psel       <= 1'b1;
                  penable    <= 1'b0;
                  grant      <= winner;
                  last_grant <= winner;
               end
            end
            SETUP: begin
               penable  <= 1'b1;
               wait_cnt <= '0;
            end
            ACCESS: begin
               if (pready) begin
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  done        <= NREQ'(1) << grant;
                  rsp_err     <= pslverr;
                  rsp_timeout <= 1'b0;
                  rsp_rdata   <= pwrite ? 32'h0 : prdata;
               end else if (timeout_hit) begin
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  done        <= NREQ'(1) << grant;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
                  rsp_rdata   <= 32'h0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            DONE: begin
               // rsp_rdata deliberately keeps its value past the pulse
               done        <= '0;
               rsp_err     <= 1'b0;
               rsp_timeout <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_ram_arbiter.sv
// Directed bench for apb_ram_arbiter with a 32-word APB RAM slave model.
// Slave supports programmable wait states, never-ready mode and pslverr for out-of-range addresses.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_apb_ram_arbiter;

   localparam int NREQ    = 2;
   localparam int TIMEOUT = 16;

   logic                pclk = 1'b0;
   logic                presetn;
   logic [NREQ-1:0]     req;
   logic [NREQ-1:0]     req_write;
   logic [32*NREQ-1:0]  req_addr;
   logic [32*NREQ-1:0]  req_wdata;
   logic [NREQ-1:0]     done;
   logic [31:0]         rsp_rdata;
   logic                rsp_err;
   logic                rsp_timeout;
   logic                psel, penable, pwrite;
   logic [31:0]         paddr, pwdata, prdata;
   logic                pready, pslverr;

   int n_checks = 0;
   int n_fail   = 0;

   // slave model state
   logic [31:0] mem [32];
   int          acc_cnt = 0;
   bit          hang    = 1'b0;
   int          nwait   = 0;

   // results captured by run_req
   int          lat, pen_cnt;
   bit          stable;
   logic [31:0] got_rdata;
   logic        got_err, got_tmo, got_psel;

   always #5 pclk = ~pclk;

   apb_ram_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .pclk(pclk), .presetn(presetn),
      .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   // APB RAM slave
   assign pready  = psel && penable && !hang && (acc_cnt >= nwait);
   assign pslverr = psel && penable && (paddr >= 32);
   assign prdata  = (paddr < 32) ? mem[paddr[4:0]] : 32'h0;

   always @(posedge pclk) begin
      if (psel && penable) acc_cnt <= acc_cnt + 1;
      else                 acc_cnt <= 0;
      if (pready && pwrite && paddr < 32) mem[paddr[4:0]] <= pwdata;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One request from requester r; waits (bounded) for done, then drops req.
   task automatic run_req(input int r, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input string tag);
      req_write[r]         = wr;
      req_addr[32*r +: 32] = a;
      req_wdata[32*r +: 32]= d;
      req[r]               = 1'b1;
      lat = 0; pen_cnt = 0; stable = 1'b1;
      do begin
         @(negedge pclk);
         lat++;
         if (psel && (paddr !== a || pwdata !== d)) stable = 1'b0;
         if (psel && penable) pen_cnt++;
      end while (done == '0 && lat < 100);
      check({tag, "_done"}, 32'(done), 32'(1) << r);
      got_rdata = rsp_rdata;
      got_err   = rsp_err;
      got_tmo   = rsp_timeout;
      got_psel  = psel;
      req[r] = 1'b0;
      @(negedge pclk);
      check({tag, "_pulse"}, 32'(done), 32'h0);
   endtask

   initial begin
      int cyc;
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      presetn = 1'b0; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge pclk);

      // reset state
      check("rst_psel",    32'(psel),        32'h0);
      check("rst_penable", 32'(penable),     32'h0);
      check("rst_pwrite",  32'(pwrite),      32'h0);
      check("rst_paddr",   paddr,            32'h0);
      check("rst_pwdata",  pwdata,           32'h0);
      check("rst_done",    32'(done),        32'h0);
      check("rst_rsp",     {rsp_rdata[29:0], rsp_err, rsp_timeout}, 32'h0);
      presetn = 1'b1;
      @(negedge pclk);

      // single write, cycle-by-cycle phases
      req_write[0] = 1'b1; req_addr[31:0] = 32'd5; req_wdata[31:0] = 32'hDEADBEEF; req[0] = 1'b1;
      @(negedge pclk);
      check("wr_t1_psel",    32'(psel),    32'h1);
      check("wr_t1_penable", 32'(penable), 32'h0);
      check("wr_t1_paddr",   paddr,        32'd5);
      @(negedge pclk);
      check("wr_t2_penable", 32'(penable), 32'h1);
      @(negedge pclk);
      check("wr_t3_done",    32'(done),    32'h1);
      check("wr_t3_err",     32'(rsp_err), 32'h0);
      check("wr_t3_psel",    32'(psel),    32'h0);
      req[0] = 1'b0;
      @(negedge pclk);
      check("wr_t4_done",    32'(done),    32'h0);

      // read back, rdata holds after the pulse
      run_req(0, 1'b0, 32'd5, 32'h0, "rd5");
      check("rd5_lat",   32'(lat), 32'd3);
      check("rd5_rdata", got_rdata, 32'hDEADBEEF);
      check("rd5_hold",  rsp_rdata, 32'hDEADBEEF);

      // three wait states from requester 1
      nwait = 3;
      run_req(1, 1'b1, 32'd20, 32'hCAFEF00D, "ws3");
      check("ws3_lat",    32'(lat),     32'd6);
      check("ws3_penacc", 32'(pen_cnt), 32'd4);
      check("ws3_stable", 32'(stable),  32'h1);
      check("ws3_rdata",  got_rdata,    32'h0);
      nwait = 0;

      // both requesters held: grants alternate 0,1,0,1 every 4 cycles
      req_write = 2'b11;
      req_addr  = {32'd11, 32'd10};
      req_wdata = {32'h22220000, 32'h11110000};
      req = 2'b11;
      for (int n = 0; n < 4; n++) begin
         cyc = 0;
         do begin
            @(negedge pclk);
            cyc++;
         end while (done == '0 && cyc < 50);
         check($sformatf("rr%0d_grant", n), 32'(done), (n % 2 == 0) ? 32'h1 : 32'h2);
         check($sformatf("rr%0d_gap", n),   32'(cyc),  (n == 0) ? 32'd3 : 32'd4);
         if (n == 3) req = 2'b00;
      end
      @(negedge pclk);
      check("rr_pulse", 32'(done), 32'h0);

      run_req(0, 1'b0, 32'd20, 32'h0, "rd20");
      check("rd20_rdata", got_rdata, 32'hCAFEF00D);
      run_req(1, 1'b0, 32'd11, 32'h0, "rd11");
      check("rd11_rdata", got_rdata, 32'h22220000);

      // out-of-range read: slave error
      run_req(0, 1'b0, 32'd40, 32'h0, "err");
      check("err_err", 32'(got_err), 32'h1);
      check("err_tmo", 32'(got_tmo), 32'h0);

      // slave never ready: abort after TIMEOUT ACCESS cycles
      hang = 1'b1;
      run_req(1, 1'b0, 32'd5, 32'h0, "tmo");
      check("tmo_lat",   32'(lat),       32'(3 + TIMEOUT - 1));
      check("tmo_err",   32'(got_err),   32'h1);
      check("tmo_tmo",   32'(got_tmo),   32'h1);
      check("tmo_rdata", got_rdata,      32'h0);
      check("tmo_psel",  32'(got_psel),  32'h0);
      check("tmo_clr",   32'({rsp_err, rsp_timeout}), 32'h0);

      // reset while in ACCESS, then re-arbitration of held req0
      req_write[0] = 1'b0; req_addr[31:0] = 32'd5; req_wdata[31:0] = 32'h0; req[0] = 1'b1;
      repeat (4) @(negedge pclk);
      check("mid_in_access", 32'({psel, penable}), 32'h3);
      presetn = 1'b0;
      @(negedge pclk);
      check("mid_rst_ctl",  32'({psel, penable, pwrite}), 32'h0);
      check("mid_rst_bus",  paddr | pwdata | rsp_rdata, 32'h0);
      check("mid_rst_done", 32'({done, rsp_err, rsp_timeout}), 32'h0);
      presetn = 1'b1;
      hang = 1'b0;
      cyc = 0;
      do begin
         @(negedge pclk);
         cyc++;
      end while (done == '0 && cyc < 50);
      check("mid_re_done",  32'(done), 32'h1);
      check("mid_re_lat",   32'(cyc),  32'd3);
      check("mid_re_rdata", rsp_rdata, 32'hDEADBEEF);
      check("mid_re_err",   32'(rsp_err), 32'h0);
      req[0] = 1'b0;
      repeat (2) @(negedge pclk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
